// File: rtl/etr_input_filter.sv
// etr_input_filter
//   Conditions the external trigger pin for the timer slave/clock logic.
//   The pin is synchronised and polarity-corrected, then either passed straight
//   through (etf_i == 0) or qualified by a digital glitch filter that samples on
//   sample_en_i. A one-cycle strobe marks each rising edge of the filtered level.
//
// Ports
//   clk_i        timer kernel clock
//   aresetn_i    asynchronous active-low reset
//   etr_i        raw external trigger pin (asynchronous)
//   etp_i        polarity: 0 = non-inverted, 1 = inverted
//   etf_i        filter config: [3:2] sample divider, [1:0] event count
//   sample_en_i  sampling tick from the ETPS divider, one clk_i wide
//   etrf_o       filtered, polarity-corrected trigger level
//   etrf_rise_o  one-cycle pulse on each 0->1 of etrf_o
module etr_input_filter #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       aresetn_i,
    input  logic       etr_i,
    input  logic       etp_i,
    input  logic [3:0] etf_i,
    input  logic       sample_en_i,
    output logic       etrf_o,
    output logic       etrf_rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   etrp;
    logic [3:0]             etf_q;
    logic [2:0]             presc_q, presc_d;
    logic [2:0]             evt_q, evt_d;
    logic                   filt_q, filt_d;
    logic                   filt_dly_q;
    logic [2:0]             div_max;
    logic [2:0]             evt_max;
    logic                   bypass;
    logic                   cfg_change;

    // Synchroniser: shift the raw pin through SYNC_STAGES flops.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], etr_i};
        end
    end

    // Polarity is applied after the synchroniser so an etp_i flip behaves like a pin edge.
    assign etrp = sync_q[SYNC_STAGES-1] ^ etp_i;

    assign bypass     = (etf_i == 4'b0000);
    assign cfg_change = (etf_i != etf_q);

    // Terminal counts: divider 1/2/4/8 and event count 2/4/6/8, both stored as value-1.
    always_comb begin
        div_max = 3'd0;
        unique case (etf_i[3:2])
            2'b00:   div_max = 3'd0;
            2'b01:   div_max = 3'd1;
            2'b10:   div_max = 3'd3;
            2'b11:   div_max = 3'd7;
            default: div_max = 3'd0;
        endcase
    end

    assign evt_max = {etf_i[1:0], 1'b1};

    always_comb begin
        presc_d = presc_q;
        evt_d   = evt_q;
        filt_d  = filt_q;
        if (cfg_change) begin
            // New configuration: restart qualification, keep the current level.
            presc_d = 3'd0;
            evt_d   = 3'd0;
        end else if (bypass) begin
            presc_d = 3'd0;
            evt_d   = 3'd0;
            filt_d  = etrp;
        end else if (sample_en_i) begin
            if (presc_q >= div_max) begin
                presc_d = 3'd0;
                if (etrp == filt_q) begin
                    evt_d = 3'd0;
                end else if (evt_q >= evt_max) begin
                    filt_d = etrp;
                    evt_d  = 3'd0;
                end else begin
                    evt_d = evt_q + 3'd1;
                end
            end else begin
                presc_d = presc_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            etf_q      <= 4'b0000;
            presc_q    <= 3'd0;
            evt_q      <= 3'd0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
        end else begin
            etf_q      <= etf_i;
            presc_q    <= presc_d;
            evt_q      <= evt_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
        end
    end

    assign etrf_o      = filt_q;
    assign etrf_rise_o = filt_q & ~filt_dly_q;

endmodule
